arith_unit_seq: RTL and testbench

//  Registered, parametrised arithmetic unit: ADD/SUB/MUL complete in one clock.
//  DIV is a multi-cycle restoring divider that returns quotient and remainder.

---
 rtl/arith_unit_seq.sv | 168 ++++++++++++++++
 tb/tb_arith_unit_seq.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/arith_unit_seq.sv
// Registered arithmetic unit: single-cycle ADD/SUB/MUL, multi-cycle restoring DIV
// with a busy/valid handshake and carry/borrow/overflow/divide-by-zero flags.
module arith_unit_seq #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             A_EN,
  input  logic [1:0]       ALU_FUN,
  input  logic [WIDTH-1:0] IN1,
  input  logic [WIDTH-1:0] IN2,
  output logic [WIDTH-1:0] Arith_Out,
  output logic [WIDTH-1:0] Rem_Out,
  output logic             Carry_Out,
  output logic             Div_Zero,
  output logic             Arith_flag,
  output logic             Busy
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

  typedef enum logic {
    IDLE,
    DIVIDE
  } state_t;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_MUL = 2'b10,
    OP_DIV = 2'b11
  } op_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] prem_q, prem_d;   // partial remainder
  logic [WIDTH-1:0] quo_q, quo_d;     // dividend shifting out, quotient shifting in
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic             carry_q, carry_d;
  logic             dz_q, dz_d;
  logic             flag_q, flag_d;

  logic [WIDTH:0]     sum;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH:0]     trial;
  logic [WIDTH:0]     diff;
  logic               ge;
  logic [WIDTH-1:0]   next_prem;
  logic [WIDTH-1:0]   next_quo;

  always_comb begin
    sum       = {1'b0, IN1} + {1'b0, IN2};
    prod      = {{WIDTH{1'b0}}, IN1} * {{WIDTH{1'b0}}, IN2};
    trial     = {prem_q, quo_q[WIDTH-1]};
    diff      = trial - {1'b0, dvs_q};
    ge        = (trial >= {1'b0, dvs_q});
    next_prem = ge ? diff[WIDTH-1:0] : trial[WIDTH-1:0];
    next_quo  = {quo_q[WIDTH-2:0], ge};
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    prem_d  = prem_q;
    quo_d   = quo_q;
    dvs_d   = dvs_q;
    out_d   = out_q;
    rem_d   = rem_q;
    carry_d = carry_q;
    dz_d    = dz_q;
    flag_d  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (A_EN) begin
          rem_d   = '0;
          carry_d = 1'b0;
          dz_d    = 1'b0;
          flag_d  = 1'b1;
          unique case (op_t'(ALU_FUN))
            OP_ADD: begin
              out_d   = sum[WIDTH-1:0];
              carry_d = sum[WIDTH];
            end
            OP_SUB: begin
              out_d   = IN1 - IN2;
              carry_d = (IN1 < IN2);
            end
            OP_MUL: begin
              out_d   = prod[WIDTH-1:0];
              carry_d = |prod[2*WIDTH-1:WIDTH];
            end
            OP_DIV: begin
              if (IN2 == '0) begin
                out_d = '1;
                rem_d = IN1;
                dz_d  = 1'b1;
              end else begin
                // Result registers keep the previous op until the last step.
                out_d   = out_q;
                rem_d   = rem_q;
                carry_d = carry_q;
                dz_d    = dz_q;
                flag_d  = 1'b0;
                state_d = DIVIDE;
                cnt_d   = CW'(WIDTH);
                prem_d  = '0;
                quo_d   = IN1;
                dvs_d   = IN2;
              end
            end
            default: ;
          endcase
        end
      end
      DIVIDE: begin
        prem_d = next_prem;
        quo_d  = next_quo;
        cnt_d  = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d = IDLE;
          out_d   = next_quo;
          rem_d   = next_prem;
          carry_d = 1'b0;
          dz_d    = 1'b0;
          flag_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      prem_q  <= '0;
      quo_q   <= '0;
      dvs_q   <= '0;
      out_q   <= '0;
      rem_q   <= '0;
      carry_q <= 1'b0;
      dz_q    <= 1'b0;
      flag_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      prem_q  <= prem_d;
      quo_q   <= quo_d;
      dvs_q   <= dvs_d;
      out_q   <= out_d;
      rem_q   <= rem_d;
      carry_q <= carry_d;
      dz_q    <= dz_d;
      flag_q  <= flag_d;
    end
  end

  assign Arith_Out  = out_q;
  assign Rem_Out    = rem_q;
  assign Carry_Out  = carry_q;
  assign Div_Zero   = dz_q;
  assign Arith_flag = flag_q;
  assign Busy       = (state_q == DIVIDE);

endmodule

// File: tb/tb_arith_unit_seq.sv
// Randomised self-checking bench for arith_unit_seq against a plain-arithmetic model.
module tb_arith_unit_seq;

  localparam int unsigned W = 16;
  localparam longint unsigned MASK = (64'd1 << W) - 64'd1;

  logic         CLK = 1'b0;
  logic         RST = 1'b0;
  logic         A_EN = 1'b0;
  logic [1:0]   ALU_FUN = 2'b00;
  logic [W-1:0] IN1 = '0;
  logic [W-1:0] IN2 = '0;
  logic [W-1:0] Arith_Out;
  logic [W-1:0] Rem_Out;
  logic         Carry_Out;
  logic         Div_Zero;
  logic         Arith_flag;
  logic         Busy;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  logic [W-1:0] e_out = '0;
  logic [W-1:0] e_rem = '0;
  logic         e_carry = 1'b0;
  logic         e_dz = 1'b0;

  arith_unit_seq #(.WIDTH(W)) dut (
    .CLK(CLK), .RST(RST), .A_EN(A_EN), .ALU_FUN(ALU_FUN), .IN1(IN1), .IN2(IN2),
    .Arith_Out(Arith_Out), .Rem_Out(Rem_Out), .Carry_Out(Carry_Out),
    .Div_Zero(Div_Zero), .Arith_flag(Arith_flag), .Busy(Busy)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_state(input bit flag_exp, input bit busy_exp);
    check("flag",  64'(Arith_flag), 64'(flag_exp));
    check("busy",  64'(Busy),       64'(busy_exp));
    check("out",   64'(Arith_Out),  64'(e_out));
    check("rem",   64'(Rem_Out),    64'(e_rem));
    check("carry", 64'(Carry_Out),  64'(e_carry));
    check("dz",    64'(Div_Zero),   64'(e_dz));
  endtask

  // Issue one op, then follow it cycle by cycle until its result appears.
  task automatic do_op(input logic [1:0] fun, input logic [W-1:0] a, input logic [W-1:0] b,
                       input bit noise);
    longint unsigned la, lb, r;
    logic [W-1:0] n_out, n_rem;
    logic n_carry, n_dz;
    int unsigned lat;
    la = 64'(a);
    lb = 64'(b);
    n_rem = '0; n_carry = 1'b0; n_dz = 1'b0; lat = 0;
    case (fun)
      2'b00: begin r = la + lb; n_out = W'(r & MASK); n_carry = (r > MASK); end
      2'b01: begin n_out = W'((la - lb) & MASK); n_carry = (la < lb); end
      2'b10: begin r = la * lb; n_out = W'(r & MASK); n_carry = ((r >> W) != 0); end
      default: begin
        if (lb == 0) begin
          n_out = W'(MASK); n_rem = a; n_dz = 1'b1;
        end else begin
          n_out = W'(la / lb); n_rem = W'(la % lb); lat = W;
        end
      end
    endcase
    A_EN = 1'b1; ALU_FUN = fun; IN1 = a; IN2 = b;
    tick();
    for (int unsigned c = 0; c <= lat; c++) begin
      if (c == lat) begin
        e_out = n_out; e_rem = n_rem; e_carry = n_carry; e_dz = n_dz;
      end
      check_state(c == lat, c < lat);
      if (c < lat) begin
        A_EN    = noise ? 1'($urandom_range(0, 1)) : 1'b0;
        ALU_FUN = 2'($urandom);
        IN1     = W'($urandom);
        IN2     = W'($urandom);
        tick();
      end
    end
    A_EN = 1'b0;
  endtask

  task automatic idle(input int unsigned n);
    A_EN = 1'b0;
    for (int unsigned i = 0; i < n; i++) begin
      tick();
      check_state(1'b0, 1'b0);
    end
  endtask

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 7))
      0: return '0;
      1: return '1;
      2: return W'(1);
      3: return W'($urandom_range(0, 15));
      default: return W'($urandom);
    endcase
  endfunction

  initial begin
    // Reset overrides a simultaneous start request.
    A_EN = 1'b1; ALU_FUN = 2'b00; IN1 = 16'hFFFF; IN2 = 16'h0001;
    tick(); tick();
    check_state(1'b0, 1'b0);
    A_EN = 1'b0;
    RST = 1'b1;
    idle(1);

    do_op(2'b00, 16'hFFFF, 16'h0001, 1'b0);
    idle(2);
    do_op(2'b01, 16'h0003, 16'h0005, 1'b0);
    do_op(2'b10, 16'h0100, 16'h0100, 1'b0);
    do_op(2'b10, 16'h00FF, 16'h0002, 1'b0);
    do_op(2'b11, 16'd1000, 16'd7, 1'b1);
    idle(2);
    do_op(2'b11, 16'h1234, 16'h0000, 1'b0);
    do_op(2'b00, 16'd1, 16'd1, 1'b0);

    // Abort a divide with reset at its fifth step.
    A_EN = 1'b1; ALU_FUN = 2'b11; IN1 = 16'hFFFF; IN2 = 16'd3;
    tick();
    A_EN = 1'b0;
    repeat (4) tick();
    RST = 1'b0;
    tick();
    e_out = '0; e_rem = '0; e_carry = 1'b0; e_dz = 1'b0;
    check_state(1'b0, 1'b0);
    RST = 1'b1;
    idle(1);
    do_op(2'b11, 16'hFFFF, 16'd3, 1'b0);

    do_op(2'b11, 16'd100, 16'd10, 1'b0);
    do_op(2'b00, 16'd2, 16'd3, 1'b0);
    idle(1);

    for (int i = 0; i < 150; i++) begin
      do_op(2'($urandom), pick(), pick(), 1'($urandom_range(0, 1)));
      idle($urandom_range(0, 2));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish, got running expected done");
    $fatal(1);
  end

endmodule
